npu_tile_sequencer: RTL and testbench
=====================================

NPU_TILE_SEQUENCER -- requirements
Module: npu_tile_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: bus data width.
REQ-002 SHALL have parameter AWIDTH, default 32: bus and buffer address width.
REQ-003 SHALL have parameter ARRAY_N, default 16: square systolic array dimension.
REQ-004 SHALL have parameter MAX_TILES, default 64: maximum tile count per job.
REQ-005 SHALL have port clk_i, in, 1: clock.
REQ-006 SHALL have port rst_ni, in, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port cen_i, in, 1: bus select, active-high.
REQ-008 SHALL have port wen_i, in, 1: 1=write, 0=read.
REQ-009 SHALL have port addr_i, in, AWIDTH: register byte offset.
REQ-010 SHALL have port wdata_i, in, DWIDTH: write data.
REQ-011 SHALL have port rdata_o, out, DWIDTH: registered read data.
REQ-012 SHALL have port a_buf_on_o / w_buf_on_o, out, 1 each: activation/weight stream enables.
REQ-013 SHALL have port a_base_o / w_base_o / o_base_o, out, AWIDTH each: current-tile buffer bases.
REQ-014 SHALL have port m_o / n_o, out, $clog2(ARRAY_N)+1 each: active rows/cols.
REQ-015 SHALL have port sa_op_o, out, 3: array op (000 idle, 100 compute, 110 shift-out).
REQ-016 SHALL have port sa_reset_o / o_ag_on_o, out, 1 each: array accumulator clear / output-buffer write enable.
REQ-017 SHALL have port busy_o / irq_o, out, 1 each: job active / one-cycle done pulse.

Function
REQ-018 SHALL decode registers on cen_i&wen_i: 0x00 CTRL (bit0 start, bit1 abort, self-clearing), 0x04 STATUS (bit0 busy, bit1 done, bit2 err; bits1-2 write-1-to-clear), 0x08 A_BASE, 0x0C M, 0x10 W_BASE, 0x14 N, 0x18 O_BASE, 0x1C K, 0x20 TILES, 0x24 A_STRIDE, 0x28 O_STRIDE.
REQ-019 SHALL return read data on rdata_o one cycle after cen_i&~wen_i; unmapped offsets read 0.
REQ-020 SHALL ignore config writes (0x08-0x28) while busy_o=1 and set err.
REQ-021 SHALL reject start when M=0, N=0, K=0, TILES=0, M>ARRAY_N, N>ARRAY_N or TILES>MAX_TILES: set err, stay IDLE.
REQ-022 SHALL ignore start while busy_o=1.
REQ-023 FSM states: IDLE, FLOW, SKEW, DRAIN, STORE, NEXT, DONE; per-state counter clears on every state change.
REQ-024 FLOW: K cycles, a_buf_on_o=w_buf_on_o=1, sa_op_o=100.
REQ-025 SKEW: M+N-1 cycles, sa_op_o=100; then DRAIN if M<ARRAY_N, else STORE.
REQ-026 DRAIN: ARRAY_N-M cycles, sa_op_o=110. STORE: M+1 cycles, sa_op_o=110, o_ag_on_o=1.
REQ-027 NEXT: one cycle, sa_reset_o=1, tile index+1, a_base_o+=A_STRIDE, o_base_o+=O_STRIDE (mod 2^AWIDTH); w_base_o unchanged; FLOW if tiles remain, else DONE.
REQ-028 DONE: one cycle, irq_o=1, sets done sticky, then IDLE.
REQ-029 Start latches A_BASE/W_BASE/O_BASE into the base outputs and clears the tile index; FLOW entered next cycle.
REQ-030 Abort in any non-IDLE state SHALL enter IDLE next cycle, assert sa_reset_o for that cycle, and SHALL NOT set done or pulse irq_o; abort and start in the same write: abort wins.
REQ-031 busy_o=1 in every state except IDLE; sa_reset_o=1 in IDLE.

Reset
REQ-032 On rst_ni low: state IDLE, all config registers, counters and status 0, rdata_o=0, sa_reset_o=1, all other outputs 0.

Configuration
REQ-033 With NPU_SEQ_PERF_EN defined: 32-bit busy-cycle counter at 0x2C, cleared on accepted start, saturates at all-ones; without it, 0x2C reads 0 and no counter logic exists.

Structure
REQ-034 Package pkg_npu_seq SHALL hold the state enum, register offset constants and op encodings.
REQ-035 Register decode/readback SHALL be sub-module npu_seq_regfile; the FSM lives in the top.

Verification
REQ-036 M=N=16, K=4, TILES=1, start -> FLOW 4, SKEW 31, no DRAIN, STORE 17, NEXT, DONE; irq_o one pulse; STATUS reads 0x2.
REQ-037 M=4, N=8, K=2, TILES=3, A_STRIDE=0x40, O_STRIDE=0x10, A_BASE=0 -> DRAIN 12 cycles per tile; a_base_o 0,0x40,0x80; one irq_o.
REQ-038 Abort in SKEW of tile 2 -> IDLE next cycle, sa_reset_o=1, done=0, no irq_o.
REQ-039 K=0 start -> STATUS=0x4, busy_o stays 0; write 0x4 to STATUS -> reads 0.
REQ-040 Write M=8 while busy -> M unchanged, err set; second start while busy -> ignored.

Source files
------------

// File: rtl/pkg_npu_seq.sv
// Shared state encoding, register map and systolic-array op codes for the NPU tile sequencer.
package pkg_npu_seq;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FLOW  = 3'd1;
    localparam state_t ST_SKEW  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_STORE = 3'd4;
    localparam state_t ST_NEXT  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_A_BASE   = 8'h08;
    localparam logic [7:0] OFF_M        = 8'h0C;
    localparam logic [7:0] OFF_W_BASE   = 8'h10;
    localparam logic [7:0] OFF_N        = 8'h14;
    localparam logic [7:0] OFF_O_BASE   = 8'h18;
    localparam logic [7:0] OFF_K        = 8'h1C;
    localparam logic [7:0] OFF_TILES    = 8'h20;
    localparam logic [7:0] OFF_A_STRIDE = 8'h24;
    localparam logic [7:0] OFF_O_STRIDE = 8'h28;
    localparam logic [7:0] OFF_PERF     = 8'h2C;

    localparam logic [2:0] OP_IDLE    = 3'b000;
    localparam logic [2:0] OP_COMPUTE = 3'b100;
    localparam logic [2:0] OP_SHIFT   = 3'b110;

    // Array operation driven while the sequencer sits in a given state.
    function automatic logic [2:0] op_of_state(input state_t st);
        logic [2:0] op;
        case (st)
            ST_FLOW, ST_SKEW:   op = OP_COMPUTE;
            ST_DRAIN, ST_STORE: op = OP_SHIFT;
            default:            op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/npu_seq_regfile.sv
// Register decode, sticky status and registered readback for the NPU tile sequencer.
// Optional busy-cycle counter at 0x2C when NPU_SEQ_PERF_EN is defined.
import pkg_npu_seq::*;

module npu_seq_regfile #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cen_i,
    input  logic              wen_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              busy_i,
    input  logic              start_ok_i,
    input  logic              err_set_i,
    input  logic              done_set_i,
    output logic              start_o,
    output logic              abort_o,
    output logic [AWIDTH-1:0] a_base_o,
    output logic [AWIDTH-1:0] w_base_o,
    output logic [AWIDTH-1:0] o_base_o,
    output logic [AWIDTH-1:0] a_stride_o,
    output logic [AWIDTH-1:0] o_stride_o,
    output logic [DWIDTH-1:0] m_o,
    output logic [DWIDTH-1:0] n_o,
    output logic [DWIDTH-1:0] k_o,
    output logic [DWIDTH-1:0] tiles_o,
    output logic [DWIDTH-1:0] rdata_o
);

    logic              hit_s, wr_s, cfg_sel_s, cfg_wr_s, cfg_rej_s, stat_wr_s;
    logic [7:0]        off_s;
    logic [DWIDTH-1:0] rd_val_s;
    logic [31:0]       perf_s;
    logic [AWIDTH-1:0] a_base_r, w_base_r, o_base_r, a_stride_r, o_stride_r;
    logic [DWIDTH-1:0] m_r, n_r, k_r, tiles_r, rdata_r;
    logic              err_r, done_r;

    assign off_s     = addr_i[7:0];
    assign hit_s     = (addr_i[AWIDTH-1:8] == '0);
    assign wr_s      = cen_i & wen_i & hit_s;
    assign start_o   = wr_s & (off_s == OFF_CTRL) & wdata_i[0];
    assign abort_o   = wr_s & (off_s == OFF_CTRL) & wdata_i[1];
    assign stat_wr_s = wr_s & (off_s == OFF_STATUS);
    assign cfg_wr_s  = wr_s & cfg_sel_s & ~busy_i;
    assign cfg_rej_s = wr_s & cfg_sel_s & busy_i;

    // Flags offsets that belong to the job configuration block.
    always_comb begin
        cfg_sel_s = 1'b0;
        case (off_s)
            OFF_A_BASE, OFF_M, OFF_W_BASE, OFF_N, OFF_O_BASE,
            OFF_K, OFF_TILES, OFF_A_STRIDE, OFF_O_STRIDE: cfg_sel_s = 1'b1;
            default:                                      cfg_sel_s = 1'b0;
        endcase
    end

    // Job configuration registers, frozen while a job runs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_base_r <= '0; w_base_r <= '0; o_base_r <= '0;
            a_stride_r <= '0; o_stride_r <= '0;
            m_r <= '0; n_r <= '0; k_r <= '0; tiles_r <= '0;
        end else if (cfg_wr_s) begin
            case (off_s)
                OFF_A_BASE:   a_base_r   <= AWIDTH'(wdata_i);
                OFF_M:        m_r        <= wdata_i;
                OFF_W_BASE:   w_base_r   <= AWIDTH'(wdata_i);
                OFF_N:        n_r        <= wdata_i;
                OFF_O_BASE:   o_base_r   <= AWIDTH'(wdata_i);
                OFF_K:        k_r        <= wdata_i;
                OFF_TILES:    tiles_r    <= wdata_i;
                OFF_A_STRIDE: a_stride_r <= AWIDTH'(wdata_i);
                OFF_O_STRIDE: o_stride_r <= AWIDTH'(wdata_i);
                default:      m_r        <= m_r;
            endcase
        end
    end

    // Sticky done/err; a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (err_set_i || cfg_rej_s) begin
                err_r <= 1'b1;
            end else if (stat_wr_s && wdata_i[2]) begin
                err_r <= 1'b0;
            end
            if (done_set_i) begin
                done_r <= 1'b1;
            end else if (stat_wr_s && wdata_i[1]) begin
                done_r <= 1'b0;
            end
        end
    end

`ifdef NPU_SEQ_PERF_EN
    logic [31:0] perf_r;

    // Busy-cycle counter, restarted by each accepted job and saturating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_r <= 32'd0;
        end else if (start_ok_i) begin
            perf_r <= 32'd0;
        end else if (busy_i && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end
    end
    assign perf_s = perf_r;
`else
    assign perf_s = 32'd0;
`endif

    // Readback multiplexer; anything outside the map reads as zero.
    always_comb begin
        rd_val_s = '0;
        if (hit_s) begin
            case (off_s)
                OFF_STATUS:   rd_val_s = DWIDTH'({err_r, done_r, busy_i});
                OFF_A_BASE:   rd_val_s = DWIDTH'(a_base_r);
                OFF_M:        rd_val_s = m_r;
                OFF_W_BASE:   rd_val_s = DWIDTH'(w_base_r);
                OFF_N:        rd_val_s = n_r;
                OFF_O_BASE:   rd_val_s = DWIDTH'(o_base_r);
                OFF_K:        rd_val_s = k_r;
                OFF_TILES:    rd_val_s = tiles_r;
                OFF_A_STRIDE: rd_val_s = DWIDTH'(a_stride_r);
                OFF_O_STRIDE: rd_val_s = DWIDTH'(o_stride_r);
                OFF_PERF:     rd_val_s = DWIDTH'(perf_s);
                default:      rd_val_s = '0;
            endcase
        end else begin
            rd_val_s = '0;
        end
    end

    // Read data is captured on the read access and held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_r <= '0;
        end else if (cen_i && !wen_i) begin
            rdata_r <= rd_val_s;
        end
    end

    assign a_base_o   = a_base_r;
    assign w_base_o   = w_base_r;
    assign o_base_o   = o_base_r;
    assign a_stride_o = a_stride_r;
    assign o_stride_o = o_stride_r;
    assign m_o        = m_r;
    assign n_o        = n_r;
    assign k_o        = k_r;
    assign tiles_o    = tiles_r;
    assign rdata_o    = rdata_r;

endmodule

// File: rtl/npu_tile_sequencer.sv
// Tile sequencer for a square systolic array: FLOW/SKEW/DRAIN/STORE per tile, then DONE.
// Define NPU_SEQ_PERF_EN to add the busy-cycle counter register.
import pkg_npu_seq::*;

module npu_tile_sequencer #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 32,
    parameter int ARRAY_N   = 16,
    parameter int MAX_TILES = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cen_i,
    input  logic                       wen_i,
    input  logic [AWIDTH-1:0]          addr_i,
    input  logic [DWIDTH-1:0]          wdata_i,
    output logic [DWIDTH-1:0]          rdata_o,
    output logic                       a_buf_on_o,
    output logic                       w_buf_on_o,
    output logic [AWIDTH-1:0]          a_base_o,
    output logic [AWIDTH-1:0]          w_base_o,
    output logic [AWIDTH-1:0]          o_base_o,
    output logic [$clog2(ARRAY_N):0]   m_o,
    output logic [$clog2(ARRAY_N):0]   n_o,
    output logic [2:0]                 sa_op_o,
    output logic                       sa_reset_o,
    output logic                       o_ag_on_o,
    output logic                       busy_o,
    output logic                       irq_o
);

    localparam int CW = $clog2(ARRAY_N) + 1;
    localparam int TW = $clog2(MAX_TILES) + 1;

    logic              start_req_s, abort_req_s, idle_s, cfg_ok_s, start_ok_s, start_bad_s;
    logic              last_tile_s;
    logic [AWIDTH-1:0] a_base_cfg_s, w_base_cfg_s, o_base_cfg_s, a_stride_cfg_s, o_stride_cfg_s;
    logic [DWIDTH-1:0] m_cfg_s, n_cfg_s, k_cfg_s, tiles_cfg_s, skew_last_s, drain_last_s;
    state_t            state_r, state_next_s;
    logic [DWIDTH-1:0] cnt_r;
    logic [TW-1:0]     tile_idx_r;
    logic [AWIDTH-1:0] a_base_r, w_base_r, o_base_r;
    logic [CW-1:0]     m_r, n_r;
    logic [2:0]        sa_op_r;
    logic              a_buf_on_r, w_buf_on_r, o_ag_on_r, sa_reset_r, busy_r, irq_r;

    npu_seq_regfile #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_regfile (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cen_i      (cen_i),
        .wen_i      (wen_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .busy_i     (~idle_s),
        .start_ok_i (start_ok_s),
        .err_set_i  (start_bad_s),
        .done_set_i (state_r == ST_DONE),
        .start_o    (start_req_s),
        .abort_o    (abort_req_s),
        .a_base_o   (a_base_cfg_s),
        .w_base_o   (w_base_cfg_s),
        .o_base_o   (o_base_cfg_s),
        .a_stride_o (a_stride_cfg_s),
        .o_stride_o (o_stride_cfg_s),
        .m_o        (m_cfg_s),
        .n_o        (n_cfg_s),
        .k_o        (k_cfg_s),
        .tiles_o    (tiles_cfg_s),
        .rdata_o    (rdata_o)
    );

    assign idle_s   = (state_r == ST_IDLE);
    assign cfg_ok_s = (m_cfg_s != '0) && (n_cfg_s != '0) && (k_cfg_s != '0) &&
                      (tiles_cfg_s != '0) && (m_cfg_s <= DWIDTH'(ARRAY_N)) &&
                      (n_cfg_s <= DWIDTH'(ARRAY_N)) && (tiles_cfg_s <= DWIDTH'(MAX_TILES));
    // A simultaneous abort cancels the start request.
    assign start_ok_s   = idle_s & start_req_s & ~abort_req_s & cfg_ok_s;
    assign start_bad_s  = idle_s & start_req_s & ~abort_req_s & ~cfg_ok_s;
    assign skew_last_s  = m_cfg_s + n_cfg_s - DWIDTH'(2);
    assign drain_last_s = DWIDTH'(ARRAY_N) - m_cfg_s - DWIDTH'(1);
    assign last_tile_s  = (DWIDTH'(tile_idx_r) + DWIDTH'(1)) >= tiles_cfg_s;

    // Next-state logic; every phase ends when the per-state counter hits its last cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = start_ok_s ? ST_FLOW : ST_IDLE;
            ST_FLOW:  state_next_s = (cnt_r == k_cfg_s - DWIDTH'(1)) ? ST_SKEW : ST_FLOW;
            ST_SKEW: begin
                if (cnt_r == skew_last_s) begin
                    state_next_s = (m_cfg_s < DWIDTH'(ARRAY_N)) ? ST_DRAIN : ST_STORE;
                end else begin
                    state_next_s = ST_SKEW;
                end
            end
            ST_DRAIN: state_next_s = (cnt_r == drain_last_s) ? ST_STORE : ST_DRAIN;
            ST_STORE: state_next_s = (cnt_r == m_cfg_s) ? ST_NEXT : ST_STORE;
            ST_NEXT:  state_next_s = last_tile_s ? ST_DONE : ST_FLOW;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
        if (abort_req_s && !idle_s) begin
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, counter, tile bookkeeping and outputs registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            tile_idx_r <= '0;
            a_base_r   <= '0;
            w_base_r   <= '0;
            o_base_r   <= '0;
            m_r        <= '0;
            n_r        <= '0;
            sa_op_r    <= OP_IDLE;
            a_buf_on_r <= 1'b0;
            w_buf_on_r <= 1'b0;
            o_ag_on_r  <= 1'b0;
            sa_reset_r <= 1'b1;
            busy_r     <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_next_s != state_r) || idle_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + DWIDTH'(1);
            end
            if (start_ok_s) begin
                a_base_r   <= a_base_cfg_s;
                w_base_r   <= w_base_cfg_s;
                o_base_r   <= o_base_cfg_s;
                m_r        <= m_cfg_s[CW-1:0];
                n_r        <= n_cfg_s[CW-1:0];
                tile_idx_r <= '0;
            end else if (state_r == ST_NEXT) begin
                a_base_r   <= a_base_r + a_stride_cfg_s;
                o_base_r   <= o_base_r + o_stride_cfg_s;
                tile_idx_r <= tile_idx_r + TW'(1);
            end
            sa_op_r    <= op_of_state(state_next_s);
            a_buf_on_r <= (state_next_s == ST_FLOW);
            w_buf_on_r <= (state_next_s == ST_FLOW);
            o_ag_on_r  <= (state_next_s == ST_STORE);
            sa_reset_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_NEXT);
            busy_r     <= (state_next_s != ST_IDLE);
            irq_r      <= (state_next_s == ST_DONE);
        end
    end

    assign a_buf_on_o = a_buf_on_r;
    assign w_buf_on_o = w_buf_on_r;
    assign a_base_o   = a_base_r;
    assign w_base_o   = w_base_r;
    assign o_base_o   = o_base_r;
    assign m_o        = m_r;
    assign n_o        = n_r;
    assign sa_op_o    = sa_op_r;
    assign o_ag_on_o  = o_ag_on_r;
    assign sa_reset_o = sa_reset_r;
    assign busy_o     = busy_r;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_npu_tile_sequencer.sv
// Scoreboard bench for npu_tile_sequencer: stimulus queues expected phases/reads, a monitor checks them.
module tb_npu_tile_sequencer;

    localparam int PH_IDLE = 0, PH_FLOW = 1, PH_SKEW = 2, PH_DRAIN = 3;
    localparam int PH_STORE = 4, PH_NEXT = 5, PH_DONE = 6, PH_BAD = 7;

    typedef struct {
        int          ph;
        int          len;
        logic [31:0] a;
        logic [31:0] o;
    } ph_rec_t;

    logic        clk = 1'b0;
    logic        rst_n, cen, wen;
    logic [31:0] addr, wdata, rdata;
    logic        a_buf_on, w_buf_on, sa_reset, o_ag_on, busy, irq;
    logic [31:0] a_base, w_base, o_base;
    logic [4:0]  m_o, n_o;
    logic [2:0]  sa_op;
    logic        rd_q;

    ph_rec_t     exp_ph[$];
    logic [31:0] exp_rd[$];
    int          checks = 0, failures = 0, irq_cnt = 0;

    npu_tile_sequencer #(.DWIDTH(32), .AWIDTH(32), .ARRAY_N(16), .MAX_TILES(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .wen_i(wen), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .a_buf_on_o(a_buf_on), .w_buf_on_o(w_buf_on),
        .a_base_o(a_base), .w_base_o(w_base), .o_base_o(o_base), .m_o(m_o), .n_o(n_o),
        .sa_op_o(sa_op), .sa_reset_o(sa_reset), .o_ag_on_o(o_ag_on), .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= 1'b0;
        else        rd_q <= cen & ~wen;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic int classify();
        if (!busy) return PH_IDLE;
        if (irq) return PH_DONE;
        if (a_buf_on && w_buf_on && sa_op == 3'b100) return PH_FLOW;
        if (sa_op == 3'b100 && !a_buf_on && !w_buf_on) return PH_SKEW;
        if (sa_op == 3'b110 && !o_ag_on) return PH_DRAIN;
        if (sa_op == 3'b110 && o_ag_on) return PH_STORE;
        if (sa_op == 3'b000 && sa_reset) return PH_NEXT;
        return PH_BAD;
    endfunction

    task automatic check_phase(input int ph, input int len, input logic [31:0] a, input logic [31:0] o);
        ph_rec_t e;
        if (exp_ph.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL phase_unexpected actual=%0d expected=none", ph);
        end else begin
            e = exp_ph.pop_front();
            chk("phase_kind", 32'(ph), 32'(e.ph));
            if (ph == e.ph && ph != PH_IDLE) chk("phase_len", 32'(len), 32'(e.len));
            if (ph == e.ph && ph == PH_FLOW) begin
                chk("flow_a_base", a, e.a);
                chk("flow_o_base", o, e.o);
            end
        end
    endtask

    // Monitor: run-length encodes the observed phases and pops read expectations.
    initial begin : monitor
        int          ph, cur_ph, run_len;
        logic [31:0] run_a, run_o, er;
        cur_ph = PH_IDLE; run_len = 0; run_a = 32'd0; run_o = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ph = classify();
                if (ph != cur_ph) begin
                    if (cur_ph != PH_IDLE) check_phase(cur_ph, run_len, run_a, run_o);
                    if (ph == PH_IDLE) begin
                        check_phase(PH_IDLE, 0, 32'd0, 32'd0);
                        chk("idle_sa_reset", 32'(sa_reset), 32'd1);
                    end
                    cur_ph = ph; run_len = 1; run_a = a_base; run_o = o_base;
                end else begin
                    run_len++;
                end
                if (irq) irq_cnt++;
                if (rd_q) begin
                    if (exp_rd.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL read_unexpected actual=0x%0h expected=none", rdata);
                    end else begin
                        er = exp_rd.pop_front();
                        chk("read_data", rdata, er);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cen = 1'b1; wen = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cen = 1'b0; wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        exp_rd.push_back(exp);
        cen = 1'b1; wen = 1'b0; addr = a;
        @(negedge clk);
        cen = 1'b0;
    endtask

    task automatic push(input int ph, input int len, input logic [31:0] a, input logic [31:0] o);
        ph_rec_t r;
        r.ph = ph; r.len = len; r.a = a; r.o = o;
        exp_ph.push_back(r);
    endtask

    // One M=4, N=8, K=2 tile: FLOW 2, SKEW 11, DRAIN 12, STORE 5, NEXT 1.
    task automatic push_small_tile(input logic [31:0] a, input logic [31:0] o);
        push(PH_FLOW, 2, a, o);
        push(PH_SKEW, 11, 32'd0, 32'd0);
        push(PH_DRAIN, 12, 32'd0, 32'd0);
        push(PH_STORE, 5, 32'd0, 32'd0);
        push(PH_NEXT, 1, 32'd0, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0; cen = 1'b0; wen = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_sa_reset", 32'(sa_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_sa_op", 32'(sa_op), 32'd0);
        chk("rst_outs", {26'd0, irq, a_buf_on, w_buf_on, o_ag_on, |a_base, |m_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(32'h04, 32'h0);
        rd(32'h0C, 32'h0);

        // Full-array single tile: no DRAIN phase.
        wr(32'h08, 32'h1000); wr(32'h0C, 32'd16); wr(32'h10, 32'h2000); wr(32'h14, 32'd16);
        wr(32'h18, 32'h3000); wr(32'h1C, 32'd4);  wr(32'h20, 32'd1);
        push(PH_FLOW, 4, 32'h1000, 32'h3000);
        push(PH_SKEW, 31, 32'd0, 32'd0);
        push(PH_STORE, 17, 32'd0, 32'd0);
        push(PH_NEXT, 1, 32'd0, 32'd0);
        push(PH_DONE, 1, 32'd0, 32'd0);
        push(PH_IDLE, 0, 32'd0, 32'd0);
        wr(32'h00, 32'h1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_m_o", 32'(m_o), 32'd16);
        chk("t1_n_o", 32'(n_o), 32'd16);
        chk("t1_w_base", w_base, 32'h2000);
        wait_idle(200);
        rd(32'h04, 32'h2);
        wr(32'h04, 32'h6);

        // Three small tiles with activation/output strides.
        wr(32'h08, 32'h0); wr(32'h0C, 32'd4); wr(32'h10, 32'h500); wr(32'h14, 32'd8);
        wr(32'h18, 32'h100); wr(32'h1C, 32'd2); wr(32'h20, 32'd3);
        wr(32'h24, 32'h40); wr(32'h28, 32'h10);
        push_small_tile(32'h00, 32'h100);
        push_small_tile(32'h40, 32'h110);
        push_small_tile(32'h80, 32'h120);
        push(PH_DONE, 1, 32'd0, 32'd0);
        push(PH_IDLE, 0, 32'd0, 32'd0);
        wr(32'h00, 32'h1);
        chk("t2_m_o", 32'(m_o), 32'd4);
        chk("t2_n_o", 32'(n_o), 32'd8);
        chk("t2_w_base", w_base, 32'h500);
        wait_idle(400);
        rd(32'h04, 32'h2);
        wr(32'h04, 32'h6);
        rd(32'h04, 32'h0);

        // Abort during SKEW of the second tile (3 SKEW cycles observed).
        push_small_tile(32'h00, 32'h100);
        push(PH_FLOW, 2, 32'h40, 32'h110);
        push(PH_SKEW, 3, 32'd0, 32'd0);
        push(PH_IDLE, 0, 32'd0, 32'd0);
        wr(32'h00, 32'h1);
        repeat (35) @(negedge clk);
        wr(32'h00, 32'h2);
        chk("t3_busy_after_abort", 32'(busy), 32'd0);
        chk("t3_sa_reset_after_abort", 32'(sa_reset), 32'd1);
        wait_idle(50);
        rd(32'h04, 32'h0);

        // K=0 start is rejected.
        wr(32'h1C, 32'd0);
        wr(32'h00, 32'h1);
        chk("t4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_busy_later", 32'(busy), 32'd0);
        rd(32'h04, 32'h4);
        wr(32'h04, 32'h4);
        rd(32'h04, 32'h0);

        // Config write and second start while busy are ignored.
        wr(32'h1C, 32'd2); wr(32'h20, 32'd1);
        push_small_tile(32'h00, 32'h100);
        push(PH_DONE, 1, 32'd0, 32'd0);
        push(PH_IDLE, 0, 32'd0, 32'd0);
        wr(32'h00, 32'h1);
        wr(32'h0C, 32'd8);
        wr(32'h00, 32'h1);
        rd(32'h0C, 32'd4);
        rd(32'h04, 32'h5);
        wait_idle(200);
        rd(32'h04, 32'h6);
        rd(32'h0C, 32'd4);

        rd(32'h24, 32'h40);
        rd(32'h28, 32'h10);
        rd(32'h20, 32'd1);
        rd(32'h10, 32'h500);
        rd(32'h2C, 32'h0);
        rd(32'h30, 32'h0);
        rd(32'h00, 32'h0);
        repeat (3) @(negedge clk);
        chk("phase_queue_empty", 32'(exp_ph.size()), 32'd0);
        chk("read_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("irq_pulses", 32'(irq_cnt), 32'd3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
